// File: rtl/cmp_dmem_arbiter.sv
// Round-robin arbiter sharing one DMEM port among NUM_CORES cores.
// Registers the granted request onto the port and routes load data back via a tag pipeline.
module cmp_dmem_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CORES-1:0]             core_req,
  input  logic [NUM_CORES-1:0]             core_wr,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]  core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_wdata,
  output logic [NUM_CORES-1:0]             core_grant,
  output logic [NUM_CORES-1:0]             core_stall,
  output logic [NUM_CORES-1:0]             core_rvalid,
  output logic [DATA_WIDTH-1:0]            core_rdata,
  output logic                             mem_en,
  output logic                             mem_wr_en,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_wdata,
  input  logic [DATA_WIDTH-1:0]            mem_rdata
);
  localparam int IDW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [IDW-1:0]                     ptr_q, ptr_d;
  logic                               mem_en_q, mem_en_d;
  logic                               mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_WIDTH-1:0]              mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]              mem_wdata_q, mem_wdata_d;
  logic [IDW-1:0]                     mem_id_q, mem_id_d;
  logic [MEM_LATENCY-1:0]             vld_pipe_q, vld_pipe_d;
  logic [MEM_LATENCY-1:0][IDW-1:0]    id_pipe_q, id_pipe_d;

  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   arb_idx;

  // Rotating search from ptr; one extra bit on the index keeps the wrap compare exact.
  always_comb begin
    gnt_vld    = 1'b0;
    gnt_id     = '0;
    arb_idx    = '0;
    core_grant = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      arb_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (arb_idx >= (IDW+1)'(NUM_CORES))
        arb_idx = arb_idx - (IDW+1)'(NUM_CORES);
      if (!gnt_vld && core_req[arb_idx[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = arb_idx[IDW-1:0];
      end
    end
    if (!reset) gnt_vld = 1'b0;
    if (gnt_vld) core_grant[gnt_id] = 1'b1;
  end

  assign core_stall = reset ? (core_req & ~core_grant) : '0;

  always_comb begin
    ptr_d       = ptr_q;
    mem_en_d    = 1'b0;
    mem_wr_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_id_d    = mem_id_q;
    if (gnt_vld) begin
      ptr_d       = (gnt_id == IDW'(NUM_CORES-1)) ? '0 : gnt_id + 1'b1;
      mem_en_d    = 1'b1;
      mem_wr_en_d = core_wr[gnt_id];
      mem_addr_d  = core_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
      mem_wdata_d = core_wdata[gnt_id*DATA_WIDTH +: DATA_WIDTH];
      mem_id_d    = gnt_id;
    end
  end

  // Tag stage 0 tracks the load currently on the port; the last stage lines up with mem_rdata.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    id_pipe_d     = id_pipe_q;
    vld_pipe_d[0] = mem_en_q & ~mem_wr_en_q;
    id_pipe_d[0]  = mem_id_q;
    for (int s = 1; s < MEM_LATENCY; s++) begin
      vld_pipe_d[s] = vld_pipe_q[s-1];
      id_pipe_d[s]  = id_pipe_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_id_q    <= '0;
      vld_pipe_q  <= '0;
      id_pipe_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mem_en_q    <= mem_en_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_id_q    <= mem_id_d;
      vld_pipe_q  <= vld_pipe_d;
      id_pipe_q   <= id_pipe_d;
    end
  end

  always_comb begin
    core_rvalid = '0;
    core_rvalid[id_pipe_q[MEM_LATENCY-1]] = vld_pipe_q[MEM_LATENCY-1];
  end

  assign core_rdata = mem_rdata;
  assign mem_en     = mem_en_q;
  assign mem_wr_en  = mem_wr_en_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_cmp_dmem_arbiter.sv
// Bench for cmp_dmem_arbiter: latency-1 and latency-3 instances share stimulus,
// each with its own memory model; load returns are scoreboarded per instance.
module tb_cmp_dmem_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  core_req, core_wr;
  logic [N*32-1:0] core_addr;
  logic [N*64-1:0] core_wdata;

  logic [N-1:0]  g1, s1, rv1, g3, s3, rv3;
  logic [63:0]   rd1, rd3, md1, md3, mr1, mr3;
  logic          me1, mw1, me3, mw3;
  logic [31:0]   ma1, ma3;

  always #5 clk = ~clk;

  cmp_dmem_arbiter #(.NUM_CORES(N), .DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .core_req(core_req), .core_wr(core_wr),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_grant(g1), .core_stall(s1),
    .core_rvalid(rv1), .core_rdata(rd1), .mem_en(me1), .mem_wr_en(mw1),
    .mem_addr(ma1), .mem_wdata(md1), .mem_rdata(mr1));

  cmp_dmem_arbiter #(.NUM_CORES(N), .DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .core_req(core_req), .core_wr(core_wr),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_grant(g3), .core_stall(s3),
    .core_rvalid(rv3), .core_rdata(rd3), .mem_en(me3), .mem_wr_en(mw3),
    .mem_addr(ma3), .mem_wdata(md3), .mem_rdata(mr3));

  // Memory models: not reset, so stale read data keeps flowing after a reset pulse.
  logic [63:0] mem1 [256];
  logic [63:0] mem3 [256];
  logic [63:0] shadow [256];
  logic [63:0] rp1;
  logic [63:0] rp3 [3];

  always @(posedge clk) begin
    if (me1 && mw1) mem1[ma1[7:0]] = md1;
    rp1 = (me1 && !mw1) ? mem1[ma1[7:0]] : {$urandom, $urandom};
    if (me3 && mw3) mem3[ma3[7:0]] = md3;
    rp3[2] = rp3[1];
    rp3[1] = rp3[0];
    rp3[0] = (me3 && !mw3) ? mem3[ma3[7:0]] : {$urandom, $urandom};
  end
  assign mr1 = rp1;
  assign mr3 = rp3[2];

  typedef struct { int due; int id; logic [63:0] data; } ret_t;
  ret_t q1[$];
  ret_t q3[$];

  int          n_chk = 0, n_pass = 0, cyc = 0;
  int          exp_ptr, exp_gid;
  bit          exp_gv;
  logic        exp_men, exp_mwr;
  logic [31:0] exp_maddr;
  logic [63:0] exp_mwd;
  logic [N-1:0] last_g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h exp %0h", tag, cyc, got, exp);
  endtask

  task automatic check_cycle();
    logic [N-1:0] eg, es;
    eg = '0;
    exp_gv = 1'b0;
    exp_gid = 0;
    if (!reset) begin
      q1.delete(); q3.delete();
      exp_ptr = 0; exp_men = 0; exp_mwr = 0; exp_maddr = '0; exp_mwd = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (exp_ptr + k) % N;
        if (!exp_gv && core_req[i]) begin exp_gv = 1'b1; exp_gid = i; end
      end
    end
    if (exp_gv) eg[exp_gid] = 1'b1;
    es = reset ? (core_req & ~eg) : '0;
    last_g = eg;
    chk("grant_l1", g1, eg);
    chk("grant_l3", g3, eg);
    chk("stall_l1", s1, es);
    chk("stall_l3", s3, es);
    chk("memport_l1", {me1, mw1, ma1}, {exp_men, exp_mwr, exp_maddr});
    chk("memport_l3", {me3, mw3, ma3}, {exp_men, exp_mwr, exp_maddr});
    chk("wdata_l1", md1, exp_mwd);
    chk("wdata_l3", md3, exp_mwd);
    if (q1.size() > 0 && q1[0].due == cyc) begin
      chk("rvalid_l1", rv1, 64'(1) << q1[0].id);
      chk("rdata_l1", rd1, q1[0].data);
      void'(q1.pop_front());
    end else chk("rvalid_l1", rv1, 64'd0);
    if (q3.size() > 0 && q3[0].due == cyc) begin
      chk("rvalid_l3", rv3, 64'(1) << q3[0].id);
      chk("rdata_l3", rd3, q3[0].data);
      void'(q3.pop_front());
    end else chk("rvalid_l3", rv3, 64'd0);
  endtask

  task automatic model_update();
    logic [63:0] d;
    if (!reset) return;
    if (exp_gv) begin
      exp_ptr   = (exp_gid + 1) % N;
      exp_men   = 1'b1;
      exp_mwr   = core_wr[exp_gid];
      exp_maddr = core_addr[exp_gid*32 +: 32];
      exp_mwd   = core_wdata[exp_gid*64 +: 64];
      if (exp_mwr) shadow[exp_maddr[7:0]] = exp_mwd;
      else begin
        d = shadow[exp_maddr[7:0]];
        q1.push_back('{cyc + 2, exp_gid, d});
        q3.push_back('{cyc + 4, exp_gid, d});
      end
    end else begin
      exp_men = 1'b0;
      exp_mwr = 1'b0;
    end
  endtask

  task automatic tick(input int n = 1);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      check_cycle();
      model_update();
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  task automatic set_core(input int i, input bit rq, input bit wr,
                          input logic [31:0] a, input logic [63:0] d);
    core_req[i]            = rq;
    core_wr[i]             = wr;
    core_addr[i*32 +: 32]  = a;
    core_wdata[i*64 +: 64] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      shadow[i] = {32'hC0DE0000 | 32'(i), 32'h0};
      mem1[i] = shadow[i];
      mem3[i] = shadow[i];
    end
    shadow[8'h40] = 64'hDEAD_BEEF;
    mem1[8'h40]   = 64'hDEAD_BEEF;
    mem3[8'h40]   = 64'hDEAD_BEEF;
    rp1 = '0;
    for (int i = 0; i < 3; i++) rp3[i] = '0;
    exp_ptr = 0; exp_men = 0; exp_mwr = 0; exp_maddr = '0; exp_mwd = '0;
    last_g = '0;

    // Reset held with every core requesting, then idle after release.
    reset = 1'b0;
    core_req = '1; core_wr = '0; core_addr = '0; core_wdata = '0;
    tick(2);
    reset = 1'b1;
    core_req = '0;
    tick(3);

    // Single load from core 2.
    set_core(2, 1, 0, 32'h40, 64'h0);
    tick();
    core_req = '0;
    tick(4);

    // Wrap from ptr 3 and skip idle cores.
    set_core(0, 1, 0, 32'h08, 64'h0);
    set_core(3, 1, 1, 32'h18, 64'h1234);
    tick(2);
    core_req = '0;
    set_core(1, 1, 0, 32'h18, 64'h0);
    tick();
    core_req = '0;
    tick(3);

    // Store from core 1 followed by a load of the same address from core 2.
    set_core(1, 1, 1, 32'h10, 64'h55);
    tick();
    core_req = '0;
    set_core(2, 1, 0, 32'h10, 64'h0);
    tick();
    core_req = '0;
    tick(6);

    // Reset pulse while a load is in flight.
    set_core(0, 1, 0, 32'h40, 64'h0);
    tick();
    core_req = '0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick(5);

    // Saturation: all cores loading.
    for (int i = 0; i < N; i++) set_core(i, 1, 0, 32'(8 * i + 32), 64'h0);
    tick(8);

    // Random traffic; a stalled core keeps its request stable.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!core_req[i] || last_g[i])
          set_core(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                   32'($urandom_range(0, 255)), {$urandom, $urandom});
      end
      tick();
    end
    core_req = '0;
    tick(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
